ysyx_220066_lsu_bridge: RTL

YSYX_220066_LSU_BRIDGE -- requirements
Module: ysyx_220066_lsu_bridge

---
 rtl/ysyx_220066_lsu_bridge_pkg.sv | 41 ++++
 rtl/ysyx_220066_lsu_bridge_if.sv | 25 ++
 rtl/ysyx_220066_lsu_bridge_align.sv | 47 ++++
 rtl/ysyx_220066_lsu_bridge.sv | 128 ++++++++++++
 4 files changed

// File: rtl/ysyx_220066_lsu_bridge_pkg.sv
// Shared types and constants for the LSU-to-bus bridge: FSM states, funct3
// load/store codes and the per-size byte strobes.
package ysyx_220066_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_RESP = 2'd3
   } lsu_state_e;

   localparam logic [2:0] MEMOP_LB  = 3'b000;
   localparam logic [2:0] MEMOP_LH  = 3'b001;
   localparam logic [2:0] MEMOP_LW  = 3'b010;
   localparam logic [2:0] MEMOP_LD  = 3'b011;
   localparam logic [2:0] MEMOP_LBU = 3'b100;
   localparam logic [2:0] MEMOP_LHU = 3'b101;
   localparam logic [2:0] MEMOP_LWU = 3'b110;

   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;
   localparam logic [1:0] SZ_D = 2'd3;

   localparam logic [7:0] MASK_B = 8'h01;
   localparam logic [7:0] MASK_H = 8'h03;
   localparam logic [7:0] MASK_W = 8'h0F;
   localparam logic [7:0] MASK_D = 8'hFF;

   function automatic logic [7:0] size_mask(input logic [1:0] sz);
      logic [7:0] m;
      case (sz)
         SZ_B:    m = MASK_B;
         SZ_H:    m = MASK_H;
         SZ_W:    m = MASK_W;
         default: m = MASK_D;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/ysyx_220066_lsu_bridge_if.sv
// Bus side of the LSU bridge: request handshake plus a response channel that
// has no back-pressure.
interface ysyx_220066_lsu_bridge_if;

   logic        req_valid;
   logic        req_ready;
   logic        req_wen;
   logic [63:0] req_addr;
   logic [63:0] req_wdata;
   logic [7:0]  req_wmask;
   logic        resp_valid;
   logic [63:0] resp_rdata;
   logic        resp_error;

   modport master (
      output req_valid, req_wen, req_addr, req_wdata, req_wmask,
      input  req_ready, resp_valid, resp_rdata, resp_error
   );

   modport slave (
      input  req_valid, req_wen, req_addr, req_wdata, req_wmask,
      output req_ready, resp_valid, resp_rdata, resp_error
   );

endinterface

// File: rtl/ysyx_220066_lsu_bridge_align.sv
// Pure datapath for the bridge: write-lane shifting and strobes, read
// alignment with sign/zero extension, and misalignment detection.
module ysyx_220066_lsu_align
   import ysyx_220066_pkg::*;
(
   input  logic [1:0]  chk_size,
   input  logic [2:0]  chk_addr_lo,
   output logic        chk_misaligned,
   input  logic [2:0]  mem_op,
   input  logic [2:0]  addr_lo,
   input  logic [63:0] wdata,
   input  logic [63:0] rdata,
   output logic [63:0] wdata_lane,
   output logic [7:0]  wmask_lane,
   output logic [63:0] rdata_ext
);

   logic [63:0] rd_shift;
   logic        sign_ext;

   // Misalignment is judged on the request as presented by the CPU, so the
   // FSM can skip the bus entirely on the acceptance edge.
   always_comb begin
      chk_misaligned = 1'b0;
      case (chk_size)
         SZ_H:    chk_misaligned = chk_addr_lo[0];
         SZ_W:    chk_misaligned = |chk_addr_lo[1:0];
         SZ_D:    chk_misaligned = |chk_addr_lo;
         default: chk_misaligned = 1'b0;
      endcase
   end

   always_comb begin
      wdata_lane = wdata << {addr_lo, 3'b000};
      wmask_lane = size_mask(mem_op[1:0]) << addr_lo;
      rd_shift   = rdata >> {addr_lo, 3'b000};
      sign_ext   = ~mem_op[2];
      rdata_ext  = 64'h0;
      case (mem_op[1:0])
         SZ_B:    rdata_ext = {{56{sign_ext & rd_shift[7]}},  rd_shift[7:0]};
         SZ_H:    rdata_ext = {{48{sign_ext & rd_shift[15]}}, rd_shift[15:0]};
         SZ_W:    rdata_ext = {{32{sign_ext & rd_shift[31]}}, rd_shift[31:0]};
         default: rdata_ext = rd_shift;
      endcase
   end

endmodule

// File: rtl/ysyx_220066_lsu_bridge.sv
// Bridges the CPU load/store port onto a valid/ready memory bus; one
// transaction at a time, completion signalled by a one-cycle pulse.
module ysyx_220066_lsu_bridge
   import ysyx_220066_pkg::*;
(
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          MemRd,
   input  logic                          MemWr,
   input  logic [2:0]                    MemOp,
   input  logic [63:0]                   addr,
   input  logic [63:0]                   data_Wr,
   output logic [63:0]                   data_Rd,
   output logic                          data_Rd_valid,
   output logic                          data_Rd_error,
   output logic                          busy,
   ysyx_220066_lsu_bridge_if.master      bus
);

   lsu_state_e  state_reg, state_next;
   logic        op_wr_reg;
   logic [2:0]  memop_reg;
   logic [63:0] addr_reg;
   logic [63:0] wdata_reg;
   logic [63:0] rdata_reg;
   logic        err_reg;

   logic        accept;
   logic        bad_req;
   logic        chk_misaligned;
   logic [63:0] wdata_lane;
   logic [7:0]  wmask_lane;
   logic [63:0] rdata_ext;

   ysyx_220066_lsu_align u_align (
      .chk_size       (MemOp[1:0]),
      .chk_addr_lo    (addr[2:0]),
      .chk_misaligned (chk_misaligned),
      .mem_op         (memop_reg),
      .addr_lo        (addr_reg[2:0]),
      .wdata          (wdata_reg),
      .rdata          (bus.resp_rdata),
      .wdata_lane     (wdata_lane),
      .wmask_lane     (wmask_lane),
      .rdata_ext      (rdata_ext)
   );

   assign accept  = (state_reg == ST_IDLE) && (MemRd || MemWr);
   assign bad_req = (MemRd && MemWr) || chk_misaligned;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // A response seen while still in REQ coincides with the handshake and is
   // a protocol violation, so only WAIT listens to resp_valid.
   always_comb begin
      state_next     = state_reg;
      bus.req_valid  = 1'b0;
      bus.req_wen    = 1'b0;
      bus.req_addr   = 64'h0;
      bus.req_wdata  = 64'h0;
      bus.req_wmask  = 8'h0;
      busy           = (state_reg != ST_IDLE);
      data_Rd_valid  = 1'b0;
      data_Rd        = 64'h0;
      data_Rd_error  = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (accept) begin
               state_next = bad_req ? ST_RESP : ST_REQ;
            end
         end
         ST_REQ: begin
            bus.req_valid = 1'b1;
            bus.req_wen   = op_wr_reg;
            bus.req_addr  = {addr_reg[63:3], 3'b000};
            if (op_wr_reg) begin
               bus.req_wdata = wdata_lane;
               bus.req_wmask = wmask_lane;
            end
            if (bus.req_ready) begin
               state_next = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (bus.resp_valid) begin
               state_next = ST_RESP;
            end
         end
         ST_RESP: begin
            data_Rd_valid = 1'b1;
            data_Rd       = rdata_reg;
            data_Rd_error = err_reg;
            state_next    = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Request fields are only meaningful while busy, so they carry no reset.
   always_ff @(posedge clk) begin
      if (accept) begin
         op_wr_reg <= MemWr;
         memop_reg <= MemOp;
         addr_reg  <= addr;
         wdata_reg <= data_Wr;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         rdata_reg <= 64'h0;
         err_reg   <= 1'b0;
      end else if (accept && bad_req) begin
         rdata_reg <= 64'h0;
         err_reg   <= 1'b1;
      end else if ((state_reg == ST_WAIT) && bus.resp_valid) begin
         err_reg   <= bus.resp_error;
         rdata_reg <= (bus.resp_error || op_wr_reg) ? 64'h0 : rdata_ext;
      end
   end

endmodule
